hazard_control_unit: RTL

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 16 +
 rtl/sat_counter.sv | 33 +++
 rtl/hazard_control_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the hazard control unit
package hazard_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_CNT_W          = 16;
    localparam int WAIT_W                 = 8;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hcu_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall, branch flush and memory-wait freeze control
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  reg_addr_t        ARS1_IF_ID,
    input  reg_addr_t        ARS2_IF_ID,
    input  logic             USES_RS1,
    input  logic             USES_RS2,
    input  reg_addr_t        ARD_ID_EX,
    input  logic             MEMREAD_ID_EX,
    input  logic             BRANCH_TAKEN_EX,
    input  logic             MEM_REQ,
    input  logic             MEM_READY,
    output logic             PC_WRITE,
    output logic             IF_ID_WRITE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_BUBBLE,
    output logic             PIPE_FREEZE,
    output logic             MEM_TIMEOUT,
    output logic [CNT_W-1:0] LOAD_STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(TIMEOUT_CYCLES);

    hcu_state_t        state_q;
    hcu_state_t        state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_inc;

    logic load_use;
    logic mem_wait;
    logic freeze;
    logic take_flush;
    logic take_stall;

    // Freeze outranks everything: a frozen EX re-presents its branch, so the
    // flush simply lands on the first unfrozen cycle and is counted once.
    always_comb begin
        load_use   = MEMREAD_ID_EX && (ARD_ID_EX != '0) &&
                     ((USES_RS1 && (ARD_ID_EX == ARS1_IF_ID)) ||
                      (USES_RS2 && (ARD_ID_EX == ARS2_IF_ID)));
        mem_wait   = MEM_REQ && !MEM_READY;
        freeze     = (state_q == TIMEOUT) || mem_wait;
        take_flush = !freeze && BRANCH_TAKEN_EX;
        take_stall = !freeze && !BRANCH_TAKEN_EX && load_use;
    end

    always_comb begin
        PC_WRITE     = !RST && !freeze && !take_stall;
        IF_ID_WRITE  = !RST && !freeze && !take_stall;
        IF_ID_FLUSH  = !RST && take_flush;
        ID_EX_BUBBLE = !RST && (take_flush || take_stall);
        PIPE_FREEZE  = !RST && freeze;
        MEM_TIMEOUT  = (state_q == TIMEOUT);
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        wait_cnt_inc = wait_cnt_q + WAIT_ONE;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (MEM_READY) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == TIMEOUT_LIM) begin
                        state_d = TIMEOUT;
                    end
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_load_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (take_stall),
        .count (LOAD_STALL_CNT)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (take_flush),
        .count (FLUSH_CNT)
    );

endmodule
